postage_maxi_deadlock_monitor_n: RTL and testbench

Parametrised deadlock monitor for HLS dataflow regions in the postage_maxi pipeline. It generalises the single-stream idx0 monitor to NUM_AXIS stream-block inputs and NUM_INST sub-instance block/idle pairs. A block is flagged only after it persists for THRESHOLD consecutive cycles. The monitor also reports which sources caused the block, the first-cause index, and how long the block has lasted. It sits beside the dataflow top and feeds the debug/status register bank.

---
 rtl/postage_maxi_deadlock_monitor_n_if.sv | 39 +++
 rtl/postage_maxi_deadlock_monitor_n.sv | 124 ++++++++++++
 tb/tb_postage_maxi_deadlock_monitor_n.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/postage_maxi_deadlock_monitor_n_if.sv
// Bundle of monitor inputs and status outputs for postage_maxi_deadlock_monitor_n.
//   master : drives the source signals, mask and clear, and reads the status outputs
//   slave  : the monitor itself
// Signals:
//   axis_block_sigs [NUM_AXIS]       per-stream blocked indication
//   inst_idle_sigs  [max(NUM_INST,1)] per-instance idle
//   inst_block_sigs [max(NUM_INST,1)] per-instance blocked
//   src_mask        [NUM_AXIS+NUM_INST] 1 = source enabled
//   clear                            synchronous clear of flag, cause and counters
//   block, block_cause, first_idx, block_cycles  registered status
interface postage_maxi_deadlock_monitor_n_if #(
  parameter int unsigned NUM_AXIS = 2,
  parameter int unsigned NUM_INST = 1,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned IDX_W    = 6
);
  localparam int unsigned INST_W = (NUM_INST == 0) ? 1 : NUM_INST;
  localparam int unsigned SRC_W  = NUM_AXIS + NUM_INST;

  logic [NUM_AXIS-1:0] axis_block_sigs;
  logic [INST_W-1:0]   inst_idle_sigs;
  logic [INST_W-1:0]   inst_block_sigs;
  logic [SRC_W-1:0]    src_mask;
  logic                clear;
  logic                block;
  logic [SRC_W-1:0]    block_cause;
  logic [IDX_W-1:0]    first_idx;
  logic [CNT_W-1:0]    block_cycles;

  modport master (
    output axis_block_sigs, inst_idle_sigs, inst_block_sigs, src_mask, clear,
    input  block, block_cause, first_idx, block_cycles
  );

  modport slave (
    input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, src_mask, clear,
    output block, block_cause, first_idx, block_cycles
  );
endinterface

// File: rtl/postage_maxi_deadlock_monitor_n.sv
// Deadlock monitor for HLS dataflow regions. Flags a block once the masked source vector
// has been non-zero for THRESHOLD consecutive cycles and reports the accumulated cause,
// the lowest source index at entry, and a saturating duration count.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset, clears all state
//   mon   : slave side of postage_maxi_deadlock_monitor_n_if (sources in, status out)
module postage_maxi_deadlock_monitor_n #(
  parameter int unsigned NUM_AXIS  = 2,
  parameter int unsigned NUM_INST  = 1,
  parameter int unsigned THRESHOLD = 1,
  parameter int unsigned STICKY    = 0,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned IDX_W     = 6
) (
  input logic clock,
  input logic reset,
  postage_maxi_deadlock_monitor_n_if.slave mon
);
  localparam int unsigned SRC_W = NUM_AXIS + NUM_INST;
  localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(THRESHOLD - 1);

  typedef enum logic [1:0] {StIdle, StPending, StBlocked} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   pcnt_q;
  logic               block_q;
  logic [SRC_W-1:0]   cause_q;
  logic [IDX_W-1:0]   first_q;
  logic [CNT_W-1:0]   cycles_q;

  logic [SRC_W-1:0]   src;
  logic               raw;
  logic [IDX_W-1:0]   low_idx;
  logic               enter;

  // Idle instances never contribute, whatever their block line says.
  if (NUM_INST > 0) begin : g_inst
    assign src = {mon.inst_block_sigs & ~mon.inst_idle_sigs, mon.axis_block_sigs}
                 & mon.src_mask;
  end else begin : g_no_inst
    assign src = mon.axis_block_sigs & mon.src_mask;
  end

  assign raw = |src;

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    low_idx = '0;
    for (int i = SRC_W - 1; i >= 0; i--) begin
      if (src[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    enter = 1'b0;
    if (raw) begin
      if (state_q == StIdle && THRESHOLD == 1) enter = 1'b1;
      if (state_q == StPending && pcnt_q == THR_M1) enter = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      pcnt_q   <= '0;
      block_q  <= 1'b0;
      cause_q  <= '0;
      first_q  <= '0;
      cycles_q <= '0;
    end else if (mon.clear) begin
      // Raw in the clear cycle is ignored; persistence restarts afterwards.
      state_q  <= StIdle;
      pcnt_q   <= '0;
      block_q  <= 1'b0;
      cause_q  <= '0;
      first_q  <= '0;
      cycles_q <= '0;
    end else if (enter) begin
      state_q  <= StBlocked;
      pcnt_q   <= '0;
      block_q  <= 1'b1;
      cause_q  <= src;
      first_q  <= low_idx;
      cycles_q <= CNT_W'(1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (raw) begin
            state_q <= StPending;
            pcnt_q  <= CNT_W'(1);
          end
        end
        StPending: begin
          if (!raw) begin
            state_q <= StIdle;
            pcnt_q  <= '0;
          end else begin
            pcnt_q <= pcnt_q + 1'b1;
          end
        end
        StBlocked: begin
          if (STICKY == 0 && !raw) begin
            // Cause, first index and duration are kept for software to read.
            state_q <= StIdle;
            block_q <= 1'b0;
          end else begin
            cause_q <= cause_q | src;
            if (cycles_q != '1) cycles_q <= cycles_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          block_q <= 1'b0;
        end
      endcase
    end
  end

  assign mon.block        = block_q;
  assign mon.block_cause  = cause_q;
  assign mon.first_idx    = first_q;
  assign mon.block_cycles = cycles_q;
endmodule

// File: tb/tb_postage_maxi_deadlock_monitor_n.sv
// Bench for postage_maxi_deadlock_monitor_n. Three instances share one stimulus stream:
//   d0: THRESHOLD=1, STICKY=0, CNT_W=4
//   d1: THRESHOLD=4, STICKY=0, CNT_W=16
//   d2: THRESHOLD=1, STICKY=1, CNT_W=16
// Expected outputs come from a run-length model and are queued per driven cycle.
module tb_postage_maxi_deadlock_monitor_n;
  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  logic [1:0] axis  = '0;
  logic       idle  = 1'b0;
  logic       iblk  = 1'b0;
  logic [2:0] mask  = 3'b111;
  logic       clr   = 1'b0;

  postage_maxi_deadlock_monitor_n_if #(.NUM_AXIS(2), .NUM_INST(1), .CNT_W(4),  .IDX_W(6)) if0 ();
  postage_maxi_deadlock_monitor_n_if #(.NUM_AXIS(2), .NUM_INST(1), .CNT_W(16), .IDX_W(6)) if1 ();
  postage_maxi_deadlock_monitor_n_if #(.NUM_AXIS(2), .NUM_INST(1), .CNT_W(16), .IDX_W(6)) if2 ();

  assign if0.axis_block_sigs = axis;
  assign if0.inst_idle_sigs  = idle;
  assign if0.inst_block_sigs = iblk;
  assign if0.src_mask        = mask;
  assign if0.clear           = clr;
  assign if1.axis_block_sigs = axis;
  assign if1.inst_idle_sigs  = idle;
  assign if1.inst_block_sigs = iblk;
  assign if1.src_mask        = mask;
  assign if1.clear           = clr;
  assign if2.axis_block_sigs = axis;
  assign if2.inst_idle_sigs  = idle;
  assign if2.inst_block_sigs = iblk;
  assign if2.src_mask        = mask;
  assign if2.clear           = clr;

  postage_maxi_deadlock_monitor_n #(
    .NUM_AXIS(2), .NUM_INST(1), .THRESHOLD(1), .STICKY(0), .CNT_W(4), .IDX_W(6)
  ) u_d0 (
    .clock (clock),
    .reset (reset),
    .mon   (if0.slave)
  );

  postage_maxi_deadlock_monitor_n #(
    .NUM_AXIS(2), .NUM_INST(1), .THRESHOLD(4), .STICKY(0), .CNT_W(16), .IDX_W(6)
  ) u_d1 (
    .clock (clock),
    .reset (reset),
    .mon   (if1.slave)
  );

  postage_maxi_deadlock_monitor_n #(
    .NUM_AXIS(2), .NUM_INST(1), .THRESHOLD(1), .STICKY(1), .CNT_W(16), .IDX_W(6)
  ) u_d2 (
    .clock (clock),
    .reset (reset),
    .mon   (if2.slave)
  );

  typedef struct packed {
    logic        blk;
    logic [2:0]  cause;
    logic [5:0]  first;
    logic [15:0] cyc;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  // Model state, one slot per instance.
  int          thr[3]  = '{1, 4, 1};
  bit          stk[3]  = '{0, 0, 1};
  int          maxc[3] = '{15, 65535, 65535};
  int          run[3];
  bit          mblk[3];
  logic [2:0]  mcause[3];
  logic [5:0]  mfirst[3];
  int          mcyc[3];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      run[d] = 0; mblk[d] = 0; mcause[d] = '0; mfirst[d] = '0; mcyc[d] = 0;
    end
  endtask

  function automatic logic [5:0] lowest(input logic [2:0] s);
    for (int i = 0; i < 3; i++) if (s[i]) return 6'(i);
    return 6'd0;
  endfunction

  // Block means "at least thr raw cycles in a row", latched for the sticky instance.
  task automatic model_step(input int d, input logic [2:0] s, input logic c);
    bit r;
    r = |s;
    if (c) begin
      run[d] = 0; mblk[d] = 0; mcause[d] = '0; mfirst[d] = '0; mcyc[d] = 0;
    end else begin
      run[d] = r ? run[d] + 1 : 0;
      if (mblk[d]) begin
        if (stk[d] || r) begin
          mcause[d] = mcause[d] | s;
          if (mcyc[d] < maxc[d]) mcyc[d]++;
        end else begin
          mblk[d] = 0;
        end
      end else if (r && run[d] >= thr[d]) begin
        mblk[d] = 1; mcause[d] = s; mfirst[d] = lowest(s); mcyc[d] = 1;
      end
    end
  endtask

  function automatic exp_t observe(input int d);
    exp_t o;
    case (d)
      0: o = '{if0.block, if0.block_cause, if0.first_idx, 16'(if0.block_cycles)};
      1: o = '{if1.block, if1.block_cause, if1.first_idx, if1.block_cycles};
      default: o = '{if2.block, if2.block_cause, if2.first_idx, if2.block_cycles};
    endcase
    return o;
  endfunction

  task automatic check_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      exp_t o;
      o = observe(d);
      check($sformatf("%s_d%0d_block", tag, d), 16'(o.blk), 16'd0);
      check($sformatf("%s_d%0d_cause", tag, d), 16'(o.cause), 16'd0);
      check($sformatf("%s_d%0d_first", tag, d), 16'(o.first), 16'd0);
      check($sformatf("%s_d%0d_cycles", tag, d), o.cyc, 16'd0);
    end
  endtask

  // Drive one cycle of inputs, queue expectations, then compare after the edge.
  task automatic step(input string tag, input logic [1:0] a, input logic ii, input logic ib,
                      input logic [2:0] m, input logic c);
    logic [2:0] s;
    axis = a; idle = ii; iblk = ib; mask = m; clr = c;
    s = {ib & ~ii, a} & m;
    for (int d = 0; d < 3; d++) begin
      model_step(d, s, c);
      sb.push_back('{mblk[d], mcause[d], mfirst[d], 16'(mcyc[d])});
    end
    @(posedge clock);
    #1;
    for (int d = 0; d < 3; d++) begin
      exp_t e, o;
      if (sb.size() == 0) begin
        check($sformatf("%s_sb_empty", tag), 16'd1, 16'd0);
      end else begin
        e = sb.pop_front();
        o = observe(d);
        check($sformatf("%s_d%0d_block", tag, d), 16'(o.blk), 16'(e.blk));
        check($sformatf("%s_d%0d_cause", tag, d), 16'(o.cause), 16'(e.cause));
        check($sformatf("%s_d%0d_first", tag, d), 16'(o.first), 16'(e.first));
        check($sformatf("%s_d%0d_cycles", tag, d), o.cyc, e.cyc);
      end
    end
  endtask

  initial begin
    model_reset();
    #1;
    check_zero("reset");
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;

    repeat (3) step("idle", 2'b00, 1'b0, 1'b0, 3'b111, 1'b0);

    // Three-cycle pulse on axis[1].
    repeat (3) step("pulse", 2'b10, 1'b0, 1'b0, 3'b111, 1'b0);
    repeat (2) step("pulse_off", 2'b00, 1'b0, 1'b0, 3'b111, 1'b0);
    check("pulse_d0_cause_fixed", 16'(if0.block_cause), 16'b010);
    check("pulse_d0_first_fixed", 16'(if0.first_idx), 16'd1);
    check("pulse_d0_cycles_fixed", 16'(if0.block_cycles), 16'd3);
    check("pulse_d0_block_dropped", 16'(if0.block), 16'd0);
    check("pulse_d1_no_block", 16'(if1.block), 16'd0);
    repeat (10) step("sticky_hold", 2'b00, 1'b0, 1'b0, 3'b111, 1'b0);
    check("sticky_d2_held", 16'(if2.block), 16'd1);
    step("clear", 2'b00, 1'b0, 1'b0, 3'b111, 1'b1);
    check_zero("after_clear");
    repeat (2) step("idle2", 2'b00, 1'b0, 1'b0, 3'b111, 1'b0);

    // Threshold-4: 3 high, 1 low, 5 high.
    repeat (3) step("thr_run1", 2'b01, 1'b0, 1'b0, 3'b111, 1'b0);
    check("thr_d1_no_block_run1", 16'(if1.block), 16'd0);
    step("thr_gap", 2'b00, 1'b0, 1'b0, 3'b111, 1'b0);
    repeat (3) step("thr_run2", 2'b01, 1'b0, 1'b0, 3'b111, 1'b0);
    check("thr_d1_still_pending", 16'(if1.block), 16'd0);
    step("thr_run2_4th", 2'b01, 1'b0, 1'b0, 3'b111, 1'b0);
    check("thr_d1_rises", 16'(if1.block), 16'd1);
    step("thr_run2_5th", 2'b01, 1'b0, 1'b0, 3'b111, 1'b0);
    step("thr_off", 2'b00, 1'b0, 1'b0, 3'b111, 1'b0);
    check("thr_d1_drops", 16'(if1.block), 16'd0);
    step("clear2", 2'b00, 1'b0, 1'b0, 3'b111, 1'b1);

    // Idle instance never contributes; busy instance does.
    repeat (5) step("inst_idle", 2'b00, 1'b1, 1'b1, 3'b111, 1'b0);
    check("inst_idle_d0_no_block", 16'(if0.block), 16'd0);
    repeat (5) step("inst_busy", 2'b00, 1'b0, 1'b1, 3'b111, 1'b0);
    check("inst_d0_cause", 16'(if0.block_cause), 16'b100);
    check("inst_d0_first", 16'(if0.first_idx), 16'd2);
    check("inst_d1_block", 16'(if1.block), 16'd1);
    step("inst_off", 2'b00, 1'b0, 1'b0, 3'b111, 1'b0);
    step("clear3", 2'b00, 1'b0, 1'b0, 3'b111, 1'b1);

    // Masking all sources mid-PENDING returns to idle and restarts persistence.
    repeat (2) step("mask_pend", 2'b01, 1'b0, 1'b0, 3'b011, 1'b0);
    step("mask_all", 2'b01, 1'b0, 1'b0, 3'b000, 1'b0);
    repeat (3) step("mask_back", 2'b01, 1'b0, 1'b0, 3'b111, 1'b0);
    check("mask_d1_no_block", 16'(if1.block), 16'd0);
    step("mask_off", 2'b00, 1'b0, 1'b0, 3'b111, 1'b0);
    step("clear4", 2'b00, 1'b0, 1'b0, 3'b111, 1'b1);

    // Saturation of the 4-bit duration counter; both axis bits accumulate.
    repeat (30) step("sat", 2'b11, 1'b0, 1'b0, 3'b111, 1'b0);
    check("sat_d0_cycles_fixed", 16'(if0.block_cycles), 16'd15);
    check("sat_d0_first_fixed", 16'(if0.first_idx), 16'd0);
    check("sat_d1_cycles_fixed", if1.block_cycles, 16'd27);

    // Clear together with raw: stays idle, then counts from scratch.
    step("clear_raw", 2'b01, 1'b0, 1'b0, 3'b111, 1'b1);
    check_zero("clear_raw_zero");
    repeat (5) step("post_clear", 2'b01, 1'b0, 1'b0, 3'b111, 1'b0);
    check("post_clear_d1_cycles", if1.block_cycles, 16'd2);

    // Asynchronous reset between edges while blocked.
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    model_reset();
    sb.delete();
    #1;
    reset = 1'b0;
    repeat (2) step("after_reset", 2'b10, 1'b0, 1'b0, 3'b111, 1'b0);
    check("after_reset_d1_pending", 16'(if1.block), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
